// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the ID/EX hazard scoreboard.
// Producer latency classes are expressed in scoreboard countdown cycles.
package hazard_scoreboard_pkg;

   localparam int REG_ADDR_W_DEF = 5;

   localparam int LAT_ALU  = 1;
   localparam int LAT_LOAD = 2;
   localparam int LAT_MUL  = 3;
   localparam int LAT_DIV  = 7;

   typedef enum logic {
      FLUSH_NONE   = 1'b0,
      FLUSH_BRANCH = 1'b1
   } flush_reason_e;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One register's in-flight write countdown with load, decrement and freeze.
// A register reads as ready once its countdown reaches 0, or 1 when forwarding is on.
module scoreboard_entry
   import hazard_scoreboard_pkg::*;
#(
   parameter int LAT_W  = 3,
   parameter int FWD_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] cnt,
   output logic             ready,
   output logic             busy
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!hold) begin
         if (load) begin
            cnt <= load_val;
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign busy  = (cnt != '0);
   assign ready = (cnt == '0) || ((FWD_EN != 0) && (cnt == LAT_W'(1)));

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard scoreboard: per-register write countdowns, RAW/WAW stall,
// multi-cycle branch flush and a saturating stall-cycle counter.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
   parameter int LAT_W        = 3,
   parameter int FWD_EN       = 1,
   parameter int FLUSH_CYCLES = 1,
   parameter int PERF_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       id_valid,
   input  logic [REG_ADDR_W-1:0]      id_rs1,
   input  logic [REG_ADDR_W-1:0]      id_rs2,
   input  logic                       id_use_rs1,
   input  logic                       id_use_rs2,
   input  logic [REG_ADDR_W-1:0]      id_rd,
   input  logic                       id_reg_write,
   input  logic [LAT_W-1:0]           id_latency,
   input  logic                       branch_taken,
   input  logic                       pipe_hold,
   output logic                       stall,
   output logic                       flush_if_id,
   output logic                       flush_id_ex,
   output logic [2**REG_ADDR_W-1:0]   busy_vec,
   output logic [PERF_W-1:0]          stall_count
);

   localparam int N    = 2**REG_ADDR_W;
   localparam int FC_W = 2;

   logic [N-1:0][LAT_W-1:0] cnt;
   logic [N-1:0]            ready_vec;
   logic [N-1:0]            busy_int;
   logic                    raw_hazard;
   logic                    waw_hazard;
   logic                    hazard;
   logic                    issue;
   logic                    load_en;
   logic [FC_W-1:0]         fcnt;
   logic [PERF_W-1:0]       stall_cnt_q;
   flush_reason_e           flush_reason;

   // x0 is hardwired: never busy, always ready
   assign cnt[0]       = '0;
   assign ready_vec[0] = 1'b1;
   assign busy_int[0]  = 1'b0;

   for (genvar r = 1; r < N; r++) begin : g_entry
      scoreboard_entry #(
         .LAT_W  (LAT_W),
         .FWD_EN (FWD_EN)
      ) u_entry (
         .clk      (clk),
         .rst      (rst),
         .hold     (pipe_hold),
         .load     (load_en && (id_rd == REG_ADDR_W'(r))),
         .load_val (id_latency),
         .cnt      (cnt[r]),
         .ready    (ready_vec[r]),
         .busy     (busy_int[r])
      );
   end

   assign raw_hazard = (id_use_rs1 && !ready_vec[id_rs1]) ||
                       (id_use_rs2 && !ready_vec[id_rs2]);
   assign waw_hazard = id_reg_write && (id_rd != '0) && (cnt[id_rd] > id_latency);
   assign hazard     = raw_hazard || waw_hazard;

   assign flush_reason = branch_taken ? FLUSH_BRANCH : FLUSH_NONE;

   // A taken branch squashes ID, so it neither stalls nor issues
   assign stall   = !rst && id_valid && (flush_reason == FLUSH_NONE) && (hazard || pipe_hold);
   assign issue   = id_valid && !stall && (flush_reason == FLUSH_NONE);
   assign load_en = issue && id_reg_write && (id_rd != '0) && (id_latency != '0);

   assign flush_id_ex = !rst && (flush_reason == FLUSH_BRANCH);
   assign flush_if_id = !rst && ((flush_reason == FLUSH_BRANCH) || (fcnt != '0));
   assign busy_vec    = busy_int;
   assign stall_count = stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt <= '0;
      end else if (flush_reason == FLUSH_BRANCH) begin
         fcnt <= FC_W'(FLUSH_CYCLES - 1);
      end else if (!pipe_hold && (fcnt != '0)) begin
         fcnt <= fcnt - 1'b1;
      end
   end

   // Only true data hazards are counted; pure back-pressure holds are not
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (id_valid && hazard && (flush_reason == FLUSH_NONE) && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario and randomized bench for hazard_scoreboard against a behavioural
// per-register countdown model held in plain integer arrays.
module tb_hazard_scoreboard;

   localparam int RW   = 5;
   localparam int LW   = 3;
   localparam int FC   = 2;
   localparam int PW   = 4;
   localparam int N    = 32;
   localparam int PMAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          id_valid = 1'b0;
   logic [RW-1:0] id_rs1 = '0;
   logic [RW-1:0] id_rs2 = '0;
   logic          id_use_rs1 = 1'b0;
   logic          id_use_rs2 = 1'b0;
   logic [RW-1:0] id_rd = '0;
   logic          id_reg_write = 1'b0;
   logic [LW-1:0] id_latency = '0;
   logic          branch_taken = 1'b0;
   logic          pipe_hold = 1'b0;
   logic          stall;
   logic          flush_if_id;
   logic          flush_id_ex;
   logic [N-1:0]  busy_vec;
   logic [PW-1:0] stall_count;

   hazard_scoreboard #(
      .REG_ADDR_W   (RW),
      .LAT_W        (LW),
      .FWD_EN       (1),
      .FLUSH_CYCLES (FC),
      .PERF_W       (PW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_latency   (id_latency),
      .branch_taken (branch_taken),
      .pipe_hold    (pipe_hold),
      .stall        (stall),
      .flush_if_id  (flush_if_id),
      .flush_id_ex  (flush_id_ex),
      .busy_vec     (busy_vec),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: remaining cycles per register, flush cycles left, stall total
   int mc [N];
   int mf;
   int msc;
   logic         e_stall, e_fif, e_fex, e_issue, e_haz;
   logic [N-1:0] e_busy;

   function automatic bit rdy(input int r);
      return (r == 0) || (mc[r] <= 1);
   endfunction

   task automatic model_reset();
      for (int r = 0; r < N; r++) mc[r] = 0;
      mf  = 0;
      msc = 0;
   endtask

   task automatic model_eval();
      bit raw, waw;
      raw = (id_use_rs1 && !rdy(int'(id_rs1))) || (id_use_rs2 && !rdy(int'(id_rs2)));
      waw = id_reg_write && (id_rd != 0) && (mc[id_rd] > int'(id_latency));
      e_haz   = raw || waw;
      e_fex   = branch_taken;
      e_stall = id_valid && !branch_taken && (e_haz || pipe_hold);
      e_issue = id_valid && !e_stall && !branch_taken;
      e_fif   = branch_taken || (mf != 0);
      for (int r = 0; r < N; r++) e_busy[r] = (mc[r] != 0);
   endtask

   task automatic tick();
      model_eval();
      if (!pipe_hold) begin
         for (int r = 1; r < N; r++) begin
            if (e_issue && id_reg_write && int'(id_rd) == r && id_latency != 0) mc[r] = int'(id_latency);
            else if (mc[r] > 0) mc[r]--;
         end
      end
      if (branch_taken) mf = FC - 1;
      else if (!pipe_hold && mf > 0) mf--;
      if (id_valid && e_haz && !branch_taken && msc < PMAX) msc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wr, input int lat, input bit br, input bit hold);
      id_valid     = v;
      id_rs1       = rs1[RW-1:0];
      id_use_rs1   = u1;
      id_rs2       = rs2[RW-1:0];
      id_use_rs2   = u2;
      id_rd        = rd[RW-1:0];
      id_reg_write = wr;
      id_latency   = lat[LW-1:0];
      branch_taken = br;
      pipe_hold    = hold;
      #2;
      model_eval();
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      drive(1, 1, 1, 2, 1, 3, 1, 2, 1, 1);
      n_cmp++;
      if ({stall, flush_if_id, flush_id_ex} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_ctrl: stall/fif/fex got %b want 000", {stall, flush_if_id, flush_id_ex});
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (busy_vec !== '0 || stall_count !== '0) begin
         n_bad++;
         $display("FAIL reset_state: busy %h cnt %0d want 0 0", busy_vec, stall_count);
      end
      rst = 1'b0;
      idle();
      tick();
   endtask

   task automatic test_alu_forward();
      drive(1, 1, 1, 2, 1, 5, 1, 1, 0, 0);
      n_cmp++;
      if (stall !== 1'b0) begin
         n_bad++;
         $display("FAIL alu_producer_stall: got %b want 0", stall);
      end
      tick();
      drive(1, 5, 1, 0, 0, 6, 1, 1, 0, 0);
      n_cmp++;
      if (stall !== 1'b0 || busy_vec[5] !== 1'b1) begin
         n_bad++;
         $display("FAIL alu_consumer: stall %b busy5 %b want 0 1", stall, busy_vec[5]);
      end
      tick();
      idle();
      n_cmp++;
      if (busy_vec !== e_busy || busy_vec[5] !== 1'b0) begin
         n_bad++;
         $display("FAIL alu_busy_clear: got %h want %h", busy_vec, e_busy);
      end
      tick();
   endtask

   task automatic test_load_use();
      int c0;
      c0 = msc;
      drive(1, 0, 0, 0, 0, 7, 1, 2, 0, 0);
      tick();
      drive(1, 7, 1, 0, 0, 13, 1, 1, 0, 0);
      n_cmp++;
      if (stall !== 1'b1 || stall !== e_stall) begin
         n_bad++;
         $display("FAIL load_use_bubble: got %b want 1", stall);
      end
      tick();
      n_cmp++;
      if (stall !== 1'b0) begin
         n_bad++;
         $display("FAIL load_use_issue: got %b want 0", stall);
      end
      n_cmp++;
      if (int'(stall_count) != c0 + 1 || int'(stall_count) != msc) begin
         n_bad++;
         $display("FAIL load_use_count: got %0d want %0d", stall_count, c0 + 1);
      end
      tick();
      idle();
      tick();
      tick();
   endtask

   task automatic test_waw_div();
      int ns;
      ns = 0;
      drive(1, 0, 0, 0, 0, 8, 1, 7, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
      for (int i = 0; i < 20 && stall === 1'b1; i++) begin
         ns++;
         tick();
         #2;
      end
      n_cmp++;
      if (ns != 6) begin
         n_bad++;
         $display("FAIL waw_stall_cycles: got %0d want 6", ns);
      end
      model_eval();
      n_cmp++;
      if (stall !== 1'b0 || stall !== e_stall) begin
         n_bad++;
         $display("FAIL waw_release: got %b want 0", stall);
      end
      tick();
      idle();
      n_cmp++;
      if (busy_vec[8] !== 1'b1 || mc[8] != 1) begin
         n_bad++;
         $display("FAIL waw_reload: busy8 %b model cnt %0d want 1 1", busy_vec[8], mc[8]);
      end
      tick();
      n_cmp++;
      if (busy_vec[8] !== 1'b0) begin
         n_bad++;
         $display("FAIL waw_drain: busy8 %b want 0", busy_vec[8]);
      end
   endtask

   task automatic test_branch_flush();
      int c0;
      drive(1, 0, 0, 0, 0, 10, 1, 2, 0, 0);
      tick();
      c0 = msc;
      drive(1, 10, 1, 0, 0, 11, 1, 1, 1, 0);
      n_cmp++;
      if ({stall, flush_if_id, flush_id_ex} !== 3'b011) begin
         n_bad++;
         $display("FAIL branch_edge: stall/fif/fex got %b want 011", {stall, flush_if_id, flush_id_ex});
      end
      tick();
      idle();
      n_cmp++;
      if ({flush_if_id, flush_id_ex} !== 2'b10 || busy_vec[11] !== 1'b0) begin
         n_bad++;
         $display("FAIL branch_second: fif/fex %b busy11 %b want 10 0", {flush_if_id, flush_id_ex}, busy_vec[11]);
      end
      tick();
      idle();
      n_cmp++;
      if (flush_if_id !== 1'b0 || int'(stall_count) != c0 || busy_vec !== e_busy) begin
         n_bad++;
         $display("FAIL branch_end: fif %b cnt %0d busy %h want 0 %0d %h", flush_if_id, stall_count, busy_vec, c0, e_busy);
      end
      tick();
      tick();
   endtask

   task automatic test_pipe_hold();
      int c0;
      drive(1, 0, 0, 0, 0, 9, 1, 2, 0, 0);
      tick();
      c0 = msc;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 0, 0, 12, 1, 1, 0, 1);
         n_cmp++;
         if (stall !== 1'b1 || busy_vec[9] !== 1'b1 || mc[9] != 2) begin
            n_bad++;
            $display("FAIL hold_freeze[%0d]: stall %b busy9 %b want 1 1", i, stall, busy_vec[9]);
         end
         tick();
      end
      n_cmp++;
      if (int'(stall_count) != c0) begin
         n_bad++;
         $display("FAIL hold_count: got %0d want %0d", stall_count, c0);
      end
      drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (stall !== 1'b1) begin
         n_bad++;
         $display("FAIL hold_after_bubble: got %b want 1", stall);
      end
      tick();
      n_cmp++;
      if (stall !== 1'b0 || int'(stall_count) != c0 + 1) begin
         n_bad++;
         $display("FAIL hold_after_issue: stall %b cnt %0d want 0 %0d", stall, stall_count, c0 + 1);
      end
      tick();
      idle();
      tick();
   endtask

   task automatic test_reset_mid();
      drive(1, 0, 0, 0, 0, 3, 1, 5, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (stall !== 1'b1 || flush_if_id !== 1'b1 || busy_vec[3] !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_pre: stall %b fif %b busy3 %b want 1 1 1", stall, flush_if_id, busy_vec[3]);
      end
      branch_taken = 1'b1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({stall, flush_if_id, flush_id_ex} !== 3'b000 || busy_vec !== '0) begin
         n_bad++;
         $display("FAIL midrst_async: ctrl %b busy %h want 000 0", {stall, flush_if_id, flush_id_ex}, busy_vec);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
      tick();
      idle();
      n_cmp++;
      if (busy_vec !== '0 || flush_if_id !== 1'b0) begin
         n_bad++;
         $display("FAIL x0_write: busy %h fif %b want 0 0", busy_vec, flush_if_id);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(1, 0),
               $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(7, 0),
               $urandom_range(1, 0), $urandom_range(7, 0),
               $urandom_range(9, 0) == 0, $urandom_range(7, 0) == 0);
         n_cmp++;
         if ({stall, flush_if_id, flush_id_ex} !== {e_stall, e_fif, e_fex}) begin
            n_bad++;
            $display("FAIL rand_ctrl[%0d]: got %b want %b", i, {stall, flush_if_id, flush_id_ex}, {e_stall, e_fif, e_fex});
         end
         n_cmp++;
         if (busy_vec !== e_busy || int'(stall_count) != msc) begin
            n_bad++;
            $display("FAIL rand_state[%0d]: busy %h cnt %0d want %h %0d", i, busy_vec, stall_count, e_busy, msc);
         end
         tick();
      end
      idle();
      n_cmp++;
      if (int'(stall_count) != msc || msc > PMAX) begin
         n_bad++;
         $display("FAIL rand_sat: got %0d want %0d", stall_count, msc);
      end
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_alu_forward();
      test_waw_div();
      test_branch_flush();
      test_pipe_hold();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
